// File: rtl/kernel_stream_source_if.sv
// AXI-Stream channel between the kernel weight source and the kernel buffer.
interface kernel_stream_source_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;
    logic             tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/kernel_stream_source.sv
// Kernel weight source: host-loaded RAM of DEPTH 3x3 kernels, streamed out as
// one AXI-Stream burst of 9*DEPTH words on request.
module kernel_stream_source #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned N     = 9 * DEPTH,
    localparam int unsigned AW    = $clog2(N)
) (
    input  logic                   i_aclk,
    input  logic                   i_aresetn,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    kernel_stream_source_if.master axis
);

    // Read address needs one spare bit so it can sit at N after the last prefetch.
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    logic [WIDTH-1:0] mem [N];

    state_t           state_q,   state_d;
    logic [CW-1:0]    rd_addr_q, rd_addr_d;
    logic [AW-1:0]    out_idx_q, out_idx_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] tdata_q,   tdata_d;
    logic             tvalid_q,  tvalid_d;
    logic             tlast_q,   tlast_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             wr_fire;
    logic             rd_en;
    logic             rd_bypass;
    logic             hs;

    // Host writes land only while idle and only inside the kernel array.
    assign wr_fire   = i_wr_en && !busy_q && ({1'b0, i_wr_addr} < CW'(N));
    // Same-cycle write to the word being read returns the new value.
    assign rd_bypass = wr_fire && ({1'b0, i_wr_addr} == rd_addr_q);
    assign hs        = tvalid_q && axis.tready;

    // RAM write port.
    always_ff @(posedge i_aclk) begin
        if (wr_fire) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Next-state, prefetch and output register control.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        out_idx_d = out_idx_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tvalid_d = 1'b0;
                if (i_start) begin
                    rd_en     = 1'b1;
                    rd_addr_d = rd_addr_q + CW'(1);
                    busy_d    = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                // Word 0 moves to the output; word 1 is prefetched behind it.
                tdata_d   = rd_data_q;
                tvalid_d  = 1'b1;
                tlast_d   = 1'b0;
                out_idx_d = '0;
                rd_en     = 1'b1;
                rd_addr_d = rd_addr_q + CW'(1);
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (hs) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        tdata_d   = rd_data_q;
                        out_idx_d = out_idx_q + AW'(1);
                        tlast_d   = (AW'(out_idx_q + AW'(1)) == AW'(N - 1));
                        if (rd_addr_q < CW'(N)) begin
                            rd_en     = 1'b1;
                            rd_addr_d = rd_addr_q + CW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                rd_addr_d = '0;
                out_idx_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Synchronous RAM read register, held while the output is stalled.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_bypass ? i_wr_data : mem[rd_addr_q[AW-1:0]];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            out_idx_q <= '0;
            rd_data_q <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            out_idx_q <= out_idx_d;
            rd_data_q <= rd_data_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign axis.tvalid = tvalid_q;
    assign axis.tdata  = tdata_q;
    assign axis.tlast  = tlast_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_kernel_stream_source.sv
// Scoreboard bench for kernel_stream_source: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_kernel_stream_source;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned N     = 9 * DEPTH;
    localparam int unsigned AW    = $clog2(N);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             tready;
    logic             busy;
    logic             done;

    kernel_stream_source_if #(.WIDTH(WIDTH)) axis ();
    assign axis.tready = tready;

    kernel_stream_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_aclk    (clk),
        .i_aresetn (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .axis      (axis)
    );

    always #5 clk = ~clk;

    exp_t             sb [$];
    logic [WIDTH-1:0] model [N];
    int               n_vec      = 0;
    int               n_err      = 0;
    int               hs_cnt     = 0;
    int               done_cnt   = 0;
    int               cyc        = 0;
    int               hs_first   = 0;
    int               hs_last    = 0;
    bit               mark_first = 1'b0;
    bit               toggle_en  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = WIDTH'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    // Queue one full burst from the model, then request it; optional same-cycle write.
    task automatic start_xfer(input bit do_wr, input int a, input int d);
        if (do_wr) begin
            model[a] = WIDTH'(d);
            wr_en    = 1'b1;
            wr_addr  = AW'(a);
            wr_data  = WIDTH'(d);
        end
        for (int i = 0; i < int'(N); i++) begin
            sb.push_back('{data: model[i], last: (i == int'(N) - 1)});
        end
        mark_first = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("tvalid_in_fetch", 32'(axis.tvalid), 32'd0);
        tick();
        chk("tvalid_rise", 32'(axis.tvalid), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: o_done not seen within %0d cycles", n);
        end else begin
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("tvalid_at_done", 32'(axis.tvalid), 32'd0);
            tick();
            chk("done_pulse_width", 32'(done), 32'd0);
        end
    endtask

    // Ready driver for the toggling-backpressure phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) tready = ~tready;
        end
    end

    // Monitor: pop and compare on each handshake, check hold under backpressure.
    initial begin
        exp_t             e;
        logic             hold_pend;
        logic [WIDTH-1:0] hd;
        logic             hl;
        hold_pend = 1'b0;
        hd        = '0;
        hl        = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                if (hold_pend) begin
                    chk("hold_tvalid", 32'(axis.tvalid), 32'd1);
                    chk("hold_tdata", 32'(axis.tdata), 32'(hd));
                    chk("hold_tlast", 32'(axis.tlast), 32'(hl));
                end
                hold_pend = 1'b0;
                if (axis.tvalid === 1'b1 && tready === 1'b0) begin
                    hold_pend = 1'b1;
                    hd        = axis.tdata;
                    hl        = axis.tlast;
                end
                if (axis.tvalid === 1'b1 && tready === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", axis.tdata, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("tdata", 32'(axis.tdata), 32'(e.data));
                        chk("tlast", 32'(axis.tlast), 32'(e.last));
                    end
                    if (mark_first) begin
                        hs_first   = cyc;
                        mark_first = 1'b0;
                    end
                    hs_last = cyc;
                    hs_cnt++;
                end
                if (done === 1'b1) done_cnt++;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        tready  = 1'b0;
        repeat (3) tick();
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tlast", 32'(axis.tlast), 32'd0);
        chk("rst_tdata", 32'(axis.tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load word i with i+1.
        for (int i = 0; i < int'(N); i++) begin
            model[i] = WIDTH'(i + 1);
            host_write(i, i + 1);
        end

        // Full-rate burst with ready held high.
        tready = 1'b1;
        start_xfer(1'b0, 0, 0);
        wait_done();
        chk("no_bubble_span", 32'(hs_last - hs_first), 32'(N - 1));
        chk("done_count_1", 32'(done_cnt), 32'd1);
        chk("sb_empty_1", 32'(sb.size()), 32'd0);

        // Toggling ready; word 0 rewritten in the same cycle as start.
        toggle_en = 1'b1;
        start_xfer(1'b1, 0, 'h55);
        wait_done();
        toggle_en = 1'b0;
        tready    = 1'b1;
        chk("done_count_2", 32'(done_cnt), 32'd2);
        chk("sb_empty_2", 32'(sb.size()), 32'd0);

        // Write while busy is dropped; word 5 still streams its old value.
        start_xfer(1'b0, 0, 0);
        host_write(5, 'hFF);
        wait_done();
        chk("done_count_3", 32'(done_cnt), 32'd3);
        chk("sb_empty_3", 32'(sb.size()), 32'd0);
        // Host retries the write once idle; the next burst carries it.
        model[5] = 8'hFF;
        host_write(5, 'hFF);
        start_xfer(1'b0, 0, 0);
        wait_done();
        chk("done_count_4", 32'(done_cnt), 32'd4);
        chk("sb_empty_4", 32'(sb.size()), 32'd0);

        // Reset after 20 handshakes abandons the burst without o_done.
        base = hs_cnt;
        start_xfer(1'b0, 0, 0);
        n = 0;
        while ((hs_cnt - base) < 20 && n < 200) begin
            tick();
            n++;
        end
        chk("hs_before_reset", 32'(hs_cnt - base), 32'd20);
        rst_n = 1'b0;
        sb.delete();
        tick();
        chk("midrst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("no_done_after_reset", 32'(done_cnt), 32'd4);
        start_xfer(1'b0, 0, 0);
        wait_done();
        chk("done_count_5", 32'(done_cnt), 32'd5);
        chk("sb_empty_5", 32'(sb.size()), 32'd0);

        // Start pulses during STREAM and during DONE are ignored.
        base = hs_cnt;
        start_xfer(1'b0, 0, 0);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("t5_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_busy_after_done", 32'(busy), 32'd0);
        repeat (20) tick();
        chk("t5_words", 32'(hs_cnt - base), 32'(N));
        chk("t5_busy_idle", 32'(busy), 32'd0);
        chk("t5_tvalid_idle", 32'(axis.tvalid), 32'd0);
        chk("done_count_6", 32'(done_cnt), 32'd6);
        chk("sb_empty_6", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
